// File: rtl/bus_initiator.sv
// bus_initiator
//   Initiator end of the system bus. Turns single-word client requests into
//   read_enable / write_enable bus cycles, waits for the responder's ready and
//   returns the result on a valid/ready response channel. One transaction is
//   outstanding at a time. Every output is registered.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   When defined, an access that sees no bus_ready for TIMEOUT_CYCLES cycles is
//   aborted and answered with rsp_err = 1, rsp_rdata = ERR_DATA. When undefined,
//   the initiator waits in ACCESS indefinitely and no counter exists.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_write               1 = write, 0 = read
//   req_addr, req_wdata     byte address (word aligned), write data
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata, rsp_err      read data (0 for writes, ERR_DATA on error), error
//   bus_addr, bus_wdata     to responder addr / data_in
//   bus_rdata               from responder data_out
//   bus_re, bus_we          to responder read_enable / write_enable
//   bus_ready               from responder ready
module bus_initiator #(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(32'hDEADBEEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_re,
  output logic              bus_we,
  input  logic              bus_ready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              bus_re_q, bus_re_d;
  logic              bus_we_q, bus_we_d;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_re_d    = bus_re_q;
    bus_we_d    = bus_we_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // req_ready is always 1 in IDLE, so req_valid alone is the handshake.
        if (req_valid) begin
          req_ready_d = 1'b0;
          bus_addr_d  = req_addr;
          bus_wdata_d = req_wdata;
          if (req_addr[1:0] != 2'b00) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = ERR_DATA;
            state_d     = ST_RESP;
          end else begin
            bus_re_d    = !req_write;
            bus_we_d    = req_write;
            state_d     = ST_ACCESS;
`ifdef BUS_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end

      ST_ACCESS: begin
        if (bus_ready) begin
          bus_re_d    = 1'b0;
          bus_we_d    = 1'b0;
          rsp_rdata_d = bus_re_q ? bus_rdata : '0;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
`ifdef BUS_TIMEOUT_EN
        // Abort on the edge where the count would reach TIMEOUT_CYCLES, so the
        // enable is visible for exactly TIMEOUT_CYCLES cycles.
        else if (cnt_q == CNT_LAST) begin
          bus_re_d    = 1'b0;
          bus_we_d    = 1'b0;
          rsp_rdata_d = ERR_DATA;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_re_q    <= 1'b0;
      bus_we_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_re_q    <= bus_re_d;
      bus_we_q    <= bus_we_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_re    = bus_re_q;
  assign bus_we    = bus_we_q;

endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator
//   Self-checking bench for bus_initiator. A simple registered-ready memory
//   responder sits on the bus side. A transaction-level model (queue of
//   expected responses plus a sparse memory image) is checked against the DUT
//   on every falling edge; directed sequences add literal latency/data checks.
`timescale 1ns/1ps
module tb_bus_initiator;

  localparam logic [31:0] ERR = 32'hDEADBEEF;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_re;
  logic        bus_we;
  logic        bus_ready;

  int total = 0;
  int bad   = 0;
  logic stall = 1'b0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  bus_initiator #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_re(bus_re),
    .bus_we(bus_we),
    .bus_ready(bus_ready)
  );

  function automatic logic [31:0] init_word(input int idx);
    return 32'h1000_0000 + 32'(idx);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder: ready and read data registered one cycle after the enable.
  logic [31:0] rmem [64];
  bit   [63:0] rwritten = '0;
  logic        rdy_r = 1'b0;
  logic [31:0] rdata_r = '0;
  always @(posedge clk) begin
    rdy_r <= (bus_re || bus_we) && !stall;
    if (bus_we && !stall) begin
      rmem[bus_addr[7:2]]     <= bus_wdata;
      rwritten[bus_addr[7:2]] <= 1'b1;
    end
    rdata_r <= rwritten[bus_addr[7:2]] ? rmem[bus_addr[7:2]] : init_word(int'(bus_addr[7:2]));
  end
  assign bus_ready = rdy_r;
  assign bus_rdata = rdata_r;

  // Transaction-level model
  typedef struct {
    logic        wr;
    logic        aligned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_wr [int];

  always @(negedge clk) begin : cmp
    bit   idle;
    exp_t e;
    int   idx;
    if (chk_en) begin
      idle = (q.size() == 0);
      chk("m_req_ready", req_ready, idle);
      chk("m_no_both_en", bus_re && bus_we, 0);
      if (idle) begin
        chk("m_idle_rsp_valid", rsp_valid, 0);
        chk("m_idle_re", bus_re, 0);
        chk("m_idle_we", bus_we, 0);
      end else if (!rsp_valid) begin
        if (!q[0].aligned) chk("m_misal_rsp_valid", rsp_valid, 1);
        else begin
          chk("m_flight_re", bus_re, !q[0].wr);
          chk("m_flight_we", bus_we, q[0].wr);
          chk("m_flight_addr", bus_addr, q[0].addr);
          if (q[0].wr) chk("m_flight_wdata", bus_wdata, q[0].wdata);
        end
      end else begin
        chk("m_rsp_re", bus_re, 0);
        chk("m_rsp_we", bus_we, 0);
        chk("m_rsp_rdata", rsp_rdata, q[0].rdata);
        chk("m_rsp_err", rsp_err, q[0].err);
      end

      if (reset) q.delete();
      else begin
        if (!idle && rsp_valid && rsp_ready) void'(q.pop_front());
        if (idle && req_valid) begin
          e.wr      = req_write;
          e.aligned = (req_addr[1:0] == 2'b00);
          e.addr    = req_addr;
          e.wdata   = req_wdata;
          idx       = int'(req_addr >> 2);
          if (!e.aligned || (TO_EN && stall)) begin
            e.err   = 1'b1;
            e.rdata = ERR;
          end else begin
            e.err = 1'b0;
            if (req_write) begin
              e.rdata       = '0;
              model_wr[idx] = req_wdata;
            end else begin
              e.rdata = model_wr.exists(idx) ? model_wr[idx] : init_word(idx);
            end
          end
          q.push_back(e);
        end
      end
    end
  end

  // Issue one request starting just after a rising edge; returns at the
  // falling edge where rsp_valid is seen, then (if rsp_ready) just after the
  // response handshake edge.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err,
                     output int lat, output int en_cyc, output time t_acc);
    int n;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) chk("accept_wait_expired", 0, 1);
    @(posedge clk);
    t_acc = $time;
    #1;
    req_valid = 1'b0;
    lat = 0;
    en_cyc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus_re || bus_we) en_cyc++;
    end while (!rsp_valid && lat < 50);
    if (!rsp_valid) chk("rsp_wait_expired", 0, 1);
    rdata = rsp_rdata;
    err   = rsp_err;
    if (rsp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, en, n;
    time         t1, t2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_re", bus_re, 0);
    chk("rst_bus_we", bus_we, 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // Aligned write then read-back
    txn(1'b1, 32'h10, 32'hCAFEF00D, rd, er, lat, en, t1);
    chk("wr_lat", lat, 3);
    chk("wr_we_cycles", en, 2);
    chk("wr_rdata", rd, 0);
    chk("wr_err", er, 0);

    txn(1'b0, 32'h10, 32'h0, rd, er, lat, en, t1);
    chk("rd_lat", lat, 3);
    chk("rd_re_cycles", en, 2);
    chk("rd_rdata", rd, 32'hCAFEF00D);
    chk("rd_err", er, 0);

    // Back-to-back: next accept exactly 4 cycles later
    txn(1'b0, 32'h14, 32'h0, rd, er, lat, en, t2);
    chk("b2b_spacing", 32'(t2 - t1), 40);
    chk("b2b_rdata", rd, 32'h1000_0005);

    // Misaligned read and write: no bus cycle, immediate error response
    txn(1'b0, 32'h13, 32'h0, rd, er, lat, en, t1);
    chk("misal_rd_lat", lat, 1);
    chk("misal_rd_en", en, 0);
    chk("misal_rd_rdata", rd, 32'hDEADBEEF);
    chk("misal_rd_err", er, 1);

    txn(1'b1, 32'h21, 32'h55, rd, er, lat, en, t1);
    chk("misal_wr_en", en, 0);
    chk("misal_wr_rdata", rd, 32'hDEADBEEF);
    chk("misal_wr_err", er, 1);
    txn(1'b0, 32'h20, 32'h0, rd, er, lat, en, t1);
    chk("misal_wr_no_effect", rd, 32'h1000_0008);

    // Response back-pressure with a pending request held by the client
    rsp_ready = 1'b0;
    txn(1'b0, 32'h10, 32'h0, rd, er, lat, en, t1);
    chk("hold_rdata", rd, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h14;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
      chk("hold_req_ready", req_ready, 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("nobypass_req_ready", req_ready, 0);
    chk("nobypass_rsp_valid", rsp_valid, 1);
    @(negedge clk);
    chk("after_rsp_req_ready", req_ready, 1);
    chk("after_rsp_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 50);
    chk("held_req_lat", n, 3);
    chk("held_req_rdata", rsp_rdata, 32'h1000_0005);
    @(posedge clk);
    #1;

    // Reset during ACCESS
    stall     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h18;
    @(negedge clk);
    chk("rst_acc_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_acc_re_before", bus_re, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("rst_acc_re_after", bus_re, 0);
    chk("rst_acc_req_ready", req_ready, 1);
    chk("rst_acc_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    txn(1'b0, 32'h18, 32'h0, rd, er, lat, en, t1);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_rdata", rd, 32'h1000_0006);
    chk("post_rst_err", er, 0);

`ifdef BUS_TIMEOUT_EN
    // Stuck responder: abort after 8 ACCESS cycles
    stall = 1'b1;
    txn(1'b0, 32'h1C, 32'h0, rd, er, lat, en, t1);
    chk("to_re_cycles", en, 8);
    chk("to_lat", lat, 9);
    chk("to_rdata", rd, 32'hDEADBEEF);
    chk("to_err", er, 1);
    stall = 1'b0;
    txn(1'b0, 32'h1C, 32'h0, rd, er, lat, en, t1);
    chk("to_recover_rdata", rd, 32'h1000_0007);
    chk("to_recover_err", er, 0);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
